ps2_key_ctrl: RTL

//  Sequencer between ps2_rx (byte receiver) and the consumer. Gates the receiver enable, runs the
//  set-2 prefix FSM (E0/F0), tracks shift state and translates make codes to ASCII. Queues

---
 rtl/ps2_key_ctrl_if.sv | 17 +
 rtl/ps2_key_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl_if.sv
// Handshake bundle between the PS/2 key sequencer, its byte receiver and
// the character consumer.
interface ps2_key_ctrl_if;
  logic       rx_done;    // one-cycle pulse: rx_data valid
  logic [7:0] rx_data;    // received scan-code byte
  logic       rx_en;      // enable back to the byte receiver
  logic       key_valid;  // FIFO head valid
  logic [7:0] key_ascii;  // FIFO head character
  logic       key_ready;  // consumer pops head on key_valid & key_ready

  // Sequencer side
  modport slave  (input  rx_done, rx_data, key_ready,
                  output rx_en, key_valid, key_ascii);
  // Receiver/consumer side
  modport master (output rx_done, rx_data, key_ready,
                  input  rx_en, key_valid, key_ascii);
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 key sequencer: decodes E0/F0 prefixes, tracks the shift keys,
// translates make codes to ASCII and queues characters in a show-ahead FIFO.
module ps2_key_ctrl #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,       // asynchronous, active-low
  input  logic                       en_i,
  ps2_key_ctrl_if.slave              bus,
  output logic                       shift_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            shift_l_q, shift_l_d;
  logic            shift_r_q, shift_r_d;
  logic            emit_vld_d;
  logic [7:0]      emit_char_d;
  logic            char_vld_q;
  logic [7:0]      char_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic            rx_en_q;

  logic            accept_s;
  logic            key_valid_s;
  logic            pop_s;
  logic            full_s;
  logic            push_ok_s;

  // Set-2 make code to ASCII; bit 8 flags a mapped code. Letters are
  // upper-cased when the shift state (before this byte) is held.
  function automatic logic [8:0] xlate(input logic [7:0] code, input logic upper);
    logic [7:0] ch;
    logic       vld;
    ch  = 8'h00;
    vld = 1'b1;
    case (code)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;  8'h25: ch = 8'h34;
      8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;  8'h3E: ch = 8'h38;
      8'h46: ch = 8'h39;  8'h45: ch = 8'h30;
      8'h29: ch = 8'h20;  8'h5A: ch = 8'h0D;  8'h66: ch = 8'h08;
      default: vld = 1'b0;
    endcase
    if (upper && (ch >= 8'h61) && (ch <= 8'h7A)) begin
      ch = ch - 8'h20;
    end else begin
      ch = ch;
    end
    return {vld, ch};
  endfunction

  assign accept_s    = en_i & bus.rx_done;
  assign key_valid_s = (count_q != CW'(0));
  assign pop_s       = key_valid_s & bus.key_ready;
  assign full_s      = (count_q == CW'(DEPTH));
  assign push_ok_s   = char_vld_q & (~full_s | pop_s);

  // Prefix FSM, prefix timeout, shift tracking and translation
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    emit_vld_d  = 1'b0;
    emit_char_d = 8'h00;
    if (accept_s) begin
      timer_d = TW'(0);
      if (bus.rx_data == 8'hE0) begin
        state_d = ST_EXT;
      end else if (bus.rx_data == 8'hF0) begin
        // F0 extends only a bare E0; anywhere else it starts a plain break
        state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      end else begin
        state_d = ST_IDLE;
        case (state_q)
          ST_IDLE: begin
            if (bus.rx_data == 8'h12) begin
              shift_l_d = 1'b1;
            end else if (bus.rx_data == 8'h59) begin
              shift_r_d = 1'b1;
            end else begin
              {emit_vld_d, emit_char_d} = xlate(bus.rx_data, shift_l_q | shift_r_q);
            end
          end
          ST_EXT: begin
            if (bus.rx_data == 8'h5A) begin
              emit_vld_d  = 1'b1;
              emit_char_d = 8'h0D;
            end else begin
              emit_vld_d  = 1'b0;
            end
          end
          ST_BRK: begin
            if (bus.rx_data == 8'h12) begin
              shift_l_d = 1'b0;
            end else if (bus.rx_data == 8'h59) begin
              shift_r_d = 1'b0;
            end else begin
              shift_l_d = shift_l_q;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (en_i && (state_q != ST_IDLE)) begin
      // A pending prefix that never gets its next byte is discarded
      if (timer_q == TMO_LAST) begin
        state_d = ST_IDLE;
        timer_d = TW'(0);
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = timer_q;
    end
  end

  // FSM state, timer, shift bits and the one-deep character stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= TW'(0);
      shift_l_q  <= 1'b0;
      shift_r_q  <= 1'b0;
      char_vld_q <= 1'b0;
      char_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      shift_l_q  <= shift_l_d;
      shift_r_q  <= shift_r_d;
      char_vld_q <= emit_vld_d;
      char_q     <= emit_char_d;
    end
  end

  // Character FIFO, overflow pulse and receiver enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      count_q    <= CW'(0);
      overflow_q <= 1'b0;
      rx_en_q    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= char_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overflow_q <= char_vld_q & full_s & ~pop_s;
      // Keep one slot free for a byte the receiver may already be shifting in
      rx_en_q    <= en_i & (count_q < CW'(DEPTH - 1));
    end
  end

  assign bus.rx_en     = rx_en_q;
  assign bus.key_valid = key_valid_s;
  assign bus.key_ascii = key_valid_s ? mem_q[rd_ptr_q] : 8'h00;
  assign shift_o       = shift_l_q | shift_r_q;
  assign overflow_o    = overflow_q;
  assign count_o       = count_q;

endmodule
